// File: rtl/load_store_unit.sv
// Multicycle load/store unit: funct3 decode, req/ack memory handshake, byte-lane steering, load extension.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are silently aligned down.
module load_store_unit #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]      state_q,    state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [XLEN-1:0] addr_q,     addr_d;
  logic [XLEN-1:0] wdata_q,    wdata_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [XLEN-1:0] rdata_q,    rdata_d;

  // Decode of the incoming request, evaluated only when start is accepted
  logic illegal;
  logic misaligned;

  always_comb begin
    illegal = (funct3 == 3'b111) || (is_store && funct3[2]) ||
              ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [OFFW-1:0] in_mask;
  always_comb begin
    in_mask    = OFFW'((4'd1 << funct3[1:0]) - 4'd1);
    misaligned = |(addr[OFFW-1:0] & in_mask);
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Lane steering from the latched request; the offset is forced to natural alignment
  logic [3:0]        sz_bytes;
  logic [OFFW-1:0]   size_mask;
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   lane_shift;
  logic [6:0]        fw;
  logic [XLEN-1:0]   field_mask;
  logic [XLEN-1:0]   field_top;
  logic [NB-1:0]     be_full;
  logic [NB-1:0]     be_lane;
  logic [XLEN-1:0]   wdata_lane;
  logic [XLEN-1:0]   rd_shift;
  logic              sign_ext;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    sz_bytes   = 4'd1 << funct3_q[1:0];
    size_mask  = OFFW'(sz_bytes - 4'd1);
    off        = addr_q[OFFW-1:0] & ~size_mask;
    lane_shift = {off, 3'b000};
    fw         = 7'd8 << funct3_q[1:0];
    field_mask = ~({XLEN{1'b1}} << fw);
    field_top  = field_mask ^ (field_mask >> 1);
    be_full    = ~({NB{1'b1}} << sz_bytes);
    be_lane    = be_full << off;
    wdata_lane = (wdata_q & field_mask) << lane_shift;
    rd_shift   = mem_rdata >> lane_shift;
    // Signed B/H/W replicate the field MSB; D and the unsigned codes do not
    sign_ext   = !funct3_q[2] && (funct3_q[1:0] != 2'b11) && (|(rd_shift & field_top));
    load_ext   = (rd_shift & field_mask) | ({XLEN{sign_ext}} & ~field_mask);
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          cnt_d      = '0;
          state_d    = (illegal || misaligned) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!is_store_q) begin
            rdata_d = load_ext;
          end
          cnt_d   = '0;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          cnt_d   = '0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory-side outputs are qualified by REQ so they read as zero outside an access
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_RESP) || (state_q == S_ERR);
    err       = (state_q == S_ERR);
    rdata     = rdata_q;
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req && is_store_q;
    mem_addr  = mem_req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    mem_wdata = mem_req ? wdata_lane : '0;
    mem_be    = mem_req ? be_lane : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=64, TIMEOUT=4); follows LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_rdata;

  load_store_unit #(.XLEN(64), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // start high for one cycle; returns at the negedge of the first post-start cycle
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    @(negedge clock);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b expected 00", {done, err}); end
    checks++; if ({mem_req, mem_we, mem_be} !== 10'd0) begin errors++; $display("FAIL reset_mem_ctl: got %h expected 0", {mem_req, mem_we, mem_be}); end
    checks++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [63:0] expv, input string nm);
    issue(1'b0, f3, 64'h1003, 64'd0);
    checks++; if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL %s_req_we: got %b expected 10", nm, {mem_req, mem_we}); end
    checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL %s_addr: got %h expected 1000", nm, mem_addr); end
    checks++; if (mem_be !== 8'h08) begin errors++; $display("FAIL %s_be: got %h expected 08", nm, mem_be); end
    mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
    @(negedge clock);
    mem_ack = 1'b0;
    exp_rdata = expv;
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL %s_done: got %b expected 10", nm, {done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata: got %h expected %h", nm, rdata, exp_rdata); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got %b expected 0", nm, busy); end
    $display("txn %s addr=1003 rdata=%h", nm, rdata);
  endtask

  task automatic test_store_half();
    issue(1'b1, 3'b001, 64'h2006, 64'h1234_5678_9ABC_BEEF);
    checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL sh_req_we: got %b expected 11", {mem_req, mem_we}); end
    checks++; if (mem_be !== 8'hC0) begin errors++; $display("FAIL sh_be: got %h expected c0", mem_be); end
    checks++; if (mem_wdata[63:48] !== 16'hBEEF) begin errors++; $display("FAIL sh_wdata: got %h expected beef", mem_wdata[63:48]); end
    checks++; if (mem_addr !== 64'h2000) begin errors++; $display("FAIL sh_addr: got %h expected 2000", mem_addr); end
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL sh_done: got %b expected 10", {done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL sh_rdata_kept: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
    $display("txn sh addr=2006 be=c0");
  endtask

  task automatic test_misaligned_lw();
    issue(1'b0, 3'b010, 64'h1002, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", mem_req); end
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL mis_err: got %b expected 11", {done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL mis_rdata_kept: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
`else
    checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL mis_addr: got %h expected 1000", mem_addr); end
    checks++; if (mem_be !== 8'h0F) begin errors++; $display("FAIL mis_be: got %h expected 0f", mem_be); end
    mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
    @(negedge clock);
    mem_ack = 1'b0;
    exp_rdata = 64'hFFFFFFFF89ABCDEF;
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL mis_done: got %b expected 10", {done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL mis_rdata: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
`endif
    $display("txn lw addr=1002 err=%b", err);
  endtask

  task automatic test_illegal();
    issue(1'b1, 3'b100, 64'h3000, 64'd0);
    checks++; if ({mem_req, done, err} !== 3'b011) begin errors++; $display("FAIL ill_store: got %b expected 011", {mem_req, done, err}); end
    @(negedge clock);
    issue(1'b0, 3'b111, 64'h3000, 64'd0);
    checks++; if ({mem_req, done, err} !== 3'b011) begin errors++; $display("FAIL ill_f3_111: got %b expected 011", {mem_req, done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL ill_rdata_kept: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
    $display("txn illegal store-100 and load-111");
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b011, 64'h3000, 64'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, done} !== 2'b10) begin errors++; $display("FAIL to_req_cycle%0d: got %b expected 10", i, {mem_req, done}); end
      @(negedge clock);
    end
    checks++; if ({mem_req, done, err} !== 3'b011) begin errors++; $display("FAIL to_err: got %b expected 011", {mem_req, done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL to_rdata_kept: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
    $display("txn ld timeout addr=3000");
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h4000;
    @(negedge clock);
    // second start while in REQ, with ack in the first REQ cycle
    addr = 64'h5008; mem_ack = 1'b1; mem_rdata = 64'hCAFEF00DDEADBEEF;
    checks++; if (mem_addr !== 64'h4000) begin errors++; $display("FAIL ld_addr: got %h expected 4000", mem_addr); end
    @(negedge clock);
    mem_ack = 1'b0;
    exp_rdata = 64'hCAFEF00DDEADBEEF;
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL ld_done: got %b expected 10", {done, err}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL ld_rdata: got %h expected %h", rdata, exp_rdata); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_start_ignored: got %b expected 0", busy); end
    start = 1'b0;
    $display("txn ld addr=4000 rdata=%h", rdata);
  endtask

  task automatic test_reset_mid_req();
    issue(1'b0, 3'b000, 64'h1003, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
    reset = 1'b0;
    #1;
    exp_rdata = 64'd0;
    checks++; if ({mem_req, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctl: got %b expected 000", {mem_req, busy, done}); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
    @(negedge clock);
    mem_ack = 1'b0;
    reset = 1'b1;
    issue(1'b0, 3'b000, 64'h1003, 64'd0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_after_req: got %b expected 1", mem_req); end
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    exp_rdata = 64'hFFFFFFFFFFFFFF89;
    checks++; if (rdata !== exp_rdata || done !== 1'b1) begin errors++; $display("FAIL rst_after_ld: got %h/%b expected %h/1", rdata, done, exp_rdata); end
    @(negedge clock);
    $display("txn reset mid-req then lb rdata=%h", rdata);
  endtask

  initial begin
    test_reset();
    test_load_byte(3'b000, 64'hFFFFFFFFFFFFFF89, "lb");
    test_load_byte(3'b100, 64'h0000000000000089, "lbu");
    test_store_half();
    test_misaligned_lw();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
